// File: rtl/sram_pattern_sequencer.sv
// SRAM test data word generator: walks an enable-masked list of 11 patterns,
// with per-word walk index and LFSR state that can be rewound for read-back.
//
// Ports:
//   clk          system clock, all state on rising edge
//   reset        asynchronous, active-high
//   start        strobe: begin at lowest enabled pattern id
//   next_pattern strobe: advance to next enabled pattern id
//   next_word    strobe: advance walk index and LFSR
//   rewind       strobe: restore walk index and LFSR to pattern start
//   pattern_en   bit i enables pattern id i
//   addr         current address, used by ADDR / ADDR_INV
//   custom       user word for CUSTOM
//   pattern      current data word (0 outside RUN)
//   pattern_id   current pattern id
//   busy         high in RUN
//   done         high in DONE
module sram_pattern_sequencer #(
    parameter int                   DATA_BITS = 16,
    parameter int                   ADDR_BITS = 20,
    parameter logic [DATA_BITS-1:0] LFSR_SEED = DATA_BITS'(1),
    parameter logic [DATA_BITS-1:0] LFSR_TAPS = DATA_BITS'(16'hB400)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 next_pattern,
    input  logic                 next_word,
    input  logic                 rewind,
    input  logic [10:0]          pattern_en,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] custom,
    output logic [DATA_BITS-1:0] pattern,
    output logic [3:0]           pattern_id,
    output logic                 busy,
    output logic                 done
);

    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [DATA_BITS-1:0] SEED =
        (LFSR_SEED == '0) ? DATA_BITS'(1) : LFSR_SEED;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [DATA_BITS-1:0] ALT_10 = {(DATA_BITS/2){2'b10}};
    localparam logic [DATA_BITS-1:0] ALT_01 = {(DATA_BITS/2){2'b01}};
    localparam logic [DATA_BITS-1:0] HALF   =
        {{(DATA_BITS/2){1'b0}}, {(DATA_BITS/2){1'b1}}};

    logic [1:0]           state;
    logic [IW-1:0]        walk;
    logic [DATA_BITS-1:0] lfsr;
    logic [DATA_BITS-1:0] lfsr_next;
    logic [DATA_BITS-1:0] addr_word;
    logic [DATA_BITS-1:0] one_hot;
    logic [3:0]           first_id;
    logic [3:0]           above_id;
    logic                 first_ok;
    logic                 above_ok;

    if (ADDR_BITS >= DATA_BITS) begin : g_addr_trunc
        assign addr_word = addr[DATA_BITS-1:0];
    end else begin : g_addr_ext
        assign addr_word = {{(DATA_BITS-ADDR_BITS){1'b0}}, addr};
    end

    assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
    assign one_hot   = {{(DATA_BITS-1){1'b0}}, 1'b1} << walk;

    // Descending scan so the last hit is the lowest matching id.
    always_comb begin
        first_id = '0;
        first_ok = 1'b0;
        above_id = '0;
        above_ok = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            if (pattern_en[i]) begin
                first_id = 4'(i);
                first_ok = 1'b1;
                if (4'(i) > pattern_id) begin
                    above_id = 4'(i);
                    above_ok = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pattern_id <= '0;
            walk       <= '0;
            lfsr       <= SEED;
        end else if (start) begin
            walk <= '0;
            lfsr <= SEED;
            if (first_ok) begin
                state      <= RUN;
                pattern_id <= first_id;
            end else begin
                state <= DONE;
            end
        end else if (state == RUN) begin
            if (next_pattern) begin
                walk <= '0;
                lfsr <= SEED;
                if (above_ok) begin
                    pattern_id <= above_id;
                end else begin
                    state <= DONE;
                end
            end else if (rewind) begin
                walk <= '0;
                lfsr <= SEED;
            end else if (next_word) begin
                walk <= (walk == LAST_IDX) ? '0 : walk + 1'b1;
                lfsr <= lfsr_next;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        pattern = '0;
        if (state == RUN) begin
            case (pattern_id)
                4'd0:    pattern = '0;
                4'd1:    pattern = '1;
                4'd2:    pattern = ALT_10;
                4'd3:    pattern = ALT_01;
                4'd4:    pattern = HALF;
                4'd5:    pattern = one_hot;
                4'd6:    pattern = ~one_hot;
                4'd7:    pattern = addr_word;
                4'd8:    pattern = ~addr_word;
                4'd9:    pattern = lfsr;
                4'd10:   pattern = custom;
                default: pattern = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_pattern_sequencer.sv
// Scoreboard bench for sram_pattern_sequencer (default parameters).
// Directed sequences followed by randomized strobes against a word-count model.
module tb_sram_pattern_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        next_pattern;
    logic        next_word;
    logic        rewind;
    logic [10:0] pattern_en;
    logic [19:0] addr;
    logic [15:0] custom;
    logic [15:0] pattern;
    logic [3:0]  pattern_id;
    logic        busy;
    logic        done;

    sram_pattern_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .next_pattern (next_pattern),
        .next_word    (next_word),
        .rewind       (rewind),
        .pattern_en   (pattern_en),
        .addr         (addr),
        .custom       (custom),
        .pattern      (pattern),
        .pattern_id   (pattern_id),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] pat;
        int          id;
        bit          busy;
        bit          done;
        bit          chk_id;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   vectors = 0;
    int   miscompares = 0;

    // Model: 0 idle, 1 run, 2 done; m_k counts words since pattern start.
    int m_state;
    int m_id;
    int m_k;

    function automatic int lowest_from(logic [10:0] en, int from);
        for (int i = from; i <= 10; i++)
            if (en[i]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] lfsr_after(int k);
        logic [15:0] s = 16'h0001;
        for (int i = 0; i < k; i++)
            s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        return s;
    endfunction

    function automatic logic [15:0] exp_pat();
        logic [15:0] one;
        if (m_state != 1) return 16'h0000;
        one = 16'h0001 << (m_k % 16);
        case (m_id)
            0:  return 16'h0000;
            1:  return 16'hFFFF;
            2:  return 16'hAAAA;
            3:  return 16'h5555;
            4:  return 16'h00FF;
            5:  return one;
            6:  return ~one;
            7:  return addr[15:0];
            8:  return ~addr[15:0];
            9:  return lfsr_after(m_k);
            10: return custom;
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic enter(int n);
        if (n < 0) begin
            m_state = 2;
        end else begin
            m_state = 1;
            m_id = n;
            m_k = 0;
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_id = 0;
        m_k = 0;
    endtask

    task automatic model_step(bit s, bit np, bit nw, bit rw);
        if (s) enter(lowest_from(pattern_en, 0));
        else if (m_state == 1) begin
            if (np) enter(lowest_from(pattern_en, m_id + 1));
            else if (rw) m_k = 0;
            else if (nw) m_k++;
        end
    endtask

    task automatic push(string name);
        exp_t e;
        e.name = name;
        e.pat = exp_pat();
        e.id = m_id;
        e.busy = (m_state == 1);
        e.done = (m_state == 2);
        e.chk_id = (m_state != 2);
        q.push_back(e);
    endtask

    // Check between edges, without waiting for a clock.
    task automatic sample(string name);
        push(name);
        ->sample_ev;
        #4;
    endtask

    // Called at posedge+1; returns at posedge+1 of the following cycle.
    task automatic cyc(bit s, bit np, bit nw, bit rw, string name);
        start = s;
        next_pattern = np;
        next_word = nw;
        rewind = rw;
        @(posedge clk);
        model_step(s, np, nw, rw);
        push(name);
        #1;
        start = 0;
        next_pattern = 0;
        next_word = 0;
        rewind = 0;
    endtask

    task automatic set_data(logic [19:0] a, logic [15:0] c, string name);
        #4;
        addr = a;
        custom = c;
        sample(name);
    endtask

    task automatic mid_reset();
        #4;
        reset = 1;
        model_reset();
        sample("async_reset");
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        exp_t e;
        bit ok;
        forever begin
            @(posedge clk or sample_ev);
            #3;
            while (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                ok = (pattern === e.pat) && (busy === e.busy) &&
                     (done === e.done) &&
                     (!e.chk_id || pattern_id === 4'(e.id));
                if (!ok) begin
                    miscompares++;
                    $display("FAIL %s: got pat=%h id=%0d busy=%b done=%b, want pat=%h id=%0d busy=%b done=%b",
                             e.name, pattern, pattern_id, busy, done,
                             e.pat, e.id, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1;
        start = 0;
        next_pattern = 0;
        next_word = 0;
        rewind = 0;
        pattern_en = 11'h7FF;
        addr = '0;
        custom = 16'hC3A5;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        sample("reset_state");
        @(posedge clk);
        #1;
        reset = 0;

        // Full walk through all patterns
        cyc(1, 0, 0, 0, "start_all");
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, "next_pat");
        for (int i = 0; i < 17; i++) cyc(0, 0, 1, 0, "walk_one");
        cyc(0, 0, 1, 1, "rewind_over_word");
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, "next_pat");
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, "lfsr_step");
        cyc(0, 0, 0, 1, "lfsr_rewind");
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, "lfsr_replay");
        cyc(0, 1, 0, 0, "to_custom");
        cyc(0, 1, 0, 0, "to_done");
        cyc(0, 1, 1, 1, "done_ignores");

        // Sparse enable with address patterns
        pattern_en = 11'h481;
        set_data(20'hABCDE, 16'h1234, "set_addr");
        cyc(1, 0, 0, 0, "sparse_start");
        cyc(0, 1, 0, 0, "sparse_addr");
        set_data(20'h00012, 16'h1234, "addr_comb");
        cyc(0, 1, 0, 0, "sparse_custom");
        cyc(0, 1, 0, 0, "sparse_done");

        // Empty and single enable masks
        pattern_en = 11'h000;
        cyc(1, 0, 0, 0, "empty_start");
        pattern_en = 11'h001;
        cyc(1, 0, 0, 0, "single_start");
        cyc(0, 1, 0, 0, "single_done");
        cyc(1, 0, 0, 0, "restart");

        // start beats next_pattern, then async reset while busy
        pattern_en = 11'h7FF;
        cyc(1, 0, 0, 0, "start_all2");
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, "next_pat2");
        cyc(1, 1, 0, 0, "start_wins");
        cyc(0, 1, 0, 0, "next_pat3");
        mid_reset();
        cyc(1, 0, 0, 0, "start_after_reset");

        // Randomized strobes
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 7) == 0)
                pattern_en = 11'h7FF;
            else
                pattern_en = 11'($urandom);
            if ($urandom_range(0, 3) == 0)
                set_data(20'($urandom), 16'($urandom), "rand_data");
            if ($urandom_range(0, 79) == 0)
                mid_reset();
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                "rand_cyc");
        end

        repeat (3) @(posedge clk);
        #5;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
